// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone instruction/data arbiter.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE  = 2'b00;
    localparam logic [1:0] OWNER_INSTR = 2'b01;
    localparam logic [1:0] OWNER_DATA  = 2'b10;

endpackage

// File: rtl/wishbone.sv
// Classic Wishbone bus bundle; MASTER drives the request side, SLAVE answers.
interface wishbone #(
    parameter int XLEN = 32
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [XLEN-1:0]   adr;
    logic [XLEN/8-1:0] sel;
    logic [XLEN-1:0]   dat_w;
    logic [XLEN-1:0]   dat_r;
    logic              ack;
    logic              err;

    modport MASTER (
        output cyc, stb, we, adr, sel, dat_w,
        input  dat_r, ack, err
    );

    modport SLAVE (
        input  cyc, stb, we, adr, sel, dat_w,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_arbiter.sv
// Two-requester Wishbone arbiter: instruction and data ports share one memory
// port. Round-robin on contention, grant held for the whole cyc, and a wait
// timeout that answers the owner with err when memory never acknowledges.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    wishbone.SLAVE     instr_bus,
    wishbone.SLAVE     data_bus,
    wishbone.MASTER    mem_bus,
    output logic [1:0] owner
);

    // Counter wide enough to hold TIMEOUT; a TIMEOUT of 0 never fires.
    localparam int            CW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

    arb_state_t    state;
    arb_state_t    state_next;
    logic          last_gnt_d;
    logic [CW-1:0] wait_cnt;
    logic          req_i;
    logic          req_d;
    logic          own_cyc;
    logic          own_stb;
    logic          timeout_hit;

    assign req_i       = instr_bus.cyc & instr_bus.stb;
    assign req_d       = data_bus.cyc & data_bus.stb;
    assign timeout_hit = (TIMEOUT != 0) && (state != IDLE) && (wait_cnt == TO_MAX);

    // Select the cyc/stb of whichever port currently owns the memory bus.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        case (state)
            GNT_I: begin
                own_cyc = instr_bus.cyc;
                own_stb = instr_bus.stb;
            end
            GNT_D: begin
                own_cyc = data_bus.cyc;
                own_stb = data_bus.stb;
            end
            default: begin
                own_cyc = 1'b0;
                own_stb = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant from IDLE only; a grant always ends back in IDLE before the next one.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_i && req_d) begin
                    state_next = last_gnt_d ? GNT_I : GNT_D;
                end else if (req_i) begin
                    state_next = GNT_I;
                end else if (req_d) begin
                    state_next = GNT_D;
                end
            end
            GNT_I, GNT_D: begin
                if (!own_cyc || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Remember which port was granted last so a tie goes to the other one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_d <= 1'b0;
        end else if (state == IDLE && state_next == GNT_I) begin
            last_gnt_d <= 1'b0;
        end else if (state == IDLE && state_next == GNT_D) begin
            last_gnt_d <= 1'b1;
        end
    end

    // Count cycles the owner strobes without an ack; cleared in IDLE and on ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else if (mem_bus.ack) begin
            wait_cnt <= '0;
        end else if (own_stb && !timeout_hit && wait_cnt != TO_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Steer the owner onto the memory bus and route responses back to it only.
    always_comb begin
        owner           = OWNER_NONE;
        mem_bus.cyc     = 1'b0;
        mem_bus.stb     = 1'b0;
        mem_bus.we      = 1'b0;
        mem_bus.adr     = {XLEN{1'b0}};
        mem_bus.sel     = '0;
        mem_bus.dat_w   = {XLEN{1'b0}};
        instr_bus.dat_r = mem_bus.dat_r;
        instr_bus.ack   = 1'b0;
        instr_bus.err   = 1'b0;
        data_bus.dat_r  = mem_bus.dat_r;
        data_bus.ack    = 1'b0;
        data_bus.err    = 1'b0;
        case (state)
            GNT_I: begin
                owner         = OWNER_INSTR;
                mem_bus.cyc   = instr_bus.cyc;
                mem_bus.stb   = instr_bus.stb & ~timeout_hit;
                mem_bus.we    = instr_bus.we;
                mem_bus.adr   = instr_bus.adr;
                mem_bus.sel   = instr_bus.sel;
                mem_bus.dat_w = instr_bus.dat_w;
                instr_bus.ack = mem_bus.ack & ~timeout_hit;
                instr_bus.err = mem_bus.err | timeout_hit;
            end
            GNT_D: begin
                owner         = OWNER_DATA;
                mem_bus.cyc   = data_bus.cyc;
                mem_bus.stb   = data_bus.stb & ~timeout_hit;
                mem_bus.we    = data_bus.we;
                mem_bus.adr   = data_bus.adr;
                mem_bus.sel   = data_bus.sel;
                mem_bus.dat_w = data_bus.dat_w;
                data_bus.ack  = mem_bus.ack & ~timeout_hit;
                data_bus.err  = mem_bus.err | timeout_hit;
            end
            default: begin
                owner = OWNER_NONE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a transaction-level grant model and
// literal checkpoints for each arbitration scenario.
module tb_wb_arbiter;

    localparam int XLEN = 32;
    localparam int TO   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] owner;

    wishbone #(.XLEN(XLEN)) ib ();
    wishbone #(.XLEN(XLEN)) db ();
    wishbone #(.XLEN(XLEN)) mb ();

    wb_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr_bus (ib),
        .data_bus  (db),
        .mem_bus   (mb),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc_no       = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus (0 none, 1 instr, 2 data), who won last, and
    // how many strobed cycles the current owner has waited without an ack.
    int m_owner = 0;
    int m_last  = 1;
    int m_wait  = 0;
    bit model_valid = 1'b0;
    bit ri, rd, pc, ps;

    function automatic bit m_timeout();
        return (m_owner != 0) && (TO > 0) && (m_wait >= TO);
    endfunction

    // Advance the model on every clock edge using the inputs held during the cycle.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_owner     = 0;
            m_last      = 1;
            m_wait      = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (m_owner == 0) begin
                ri = ib.cyc && ib.stb;
                rd = db.cyc && db.stb;
                if (ri && rd)  m_owner = (m_last == 2) ? 1 : 2;
                else if (ri)   m_owner = 1;
                else if (rd)   m_owner = 2;
                if (m_owner != 0) begin
                    m_last = m_owner;
                    m_wait = 0;
                end
            end else begin
                pc = (m_owner == 1) ? ib.cyc : db.cyc;
                ps = (m_owner == 1) ? ib.stb : db.stb;
                if (m_timeout() || !pc) m_owner = 0;
                else if (mb.ack)        m_wait = 0;
                else if (ps)            m_wait++;
            end
        end
    end

    bit              to_now, g_i, g_d, e_cyc, e_stb, e_we;
    logic [31:0]     e_adr, e_dw;
    logic [3:0]      e_sel;

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clk) begin
        if (model_valid) begin
            to_now = m_timeout();
            g_i    = (m_owner == 1);
            g_d    = (m_owner == 2);
            e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_sel = '0; e_dw = '0;
            if (g_i) begin
                e_cyc = ib.cyc; e_stb = ib.stb; e_we = ib.we; e_adr = ib.adr; e_sel = ib.sel; e_dw = ib.dat_w;
            end else if (g_d) begin
                e_cyc = db.cyc; e_stb = db.stb; e_we = db.we; e_adr = db.adr; e_sel = db.sel; e_dw = db.dat_w;
            end
            checkOutput("owner", 32'(owner), 32'(m_owner));
            checkOutput("mem_cyc", 32'(mb.cyc), 32'(e_cyc));
            checkOutput("mem_stb", 32'(mb.stb), 32'(e_stb && !to_now));
            if (g_i || g_d) begin
                checkOutput("mem_adr", mb.adr, e_adr);
                checkOutput("mem_we", 32'(mb.we), 32'(e_we));
                checkOutput("mem_sel", 32'(mb.sel), 32'(e_sel));
                checkOutput("mem_dat_w", mb.dat_w, e_dw);
            end
            if (g_i) checkOutput("instr_dat_r", ib.dat_r, mb.dat_r);
            if (g_d) checkOutput("data_dat_r", db.dat_r, mb.dat_r);
            checkOutput("instr_ack", 32'(ib.ack), 32'(g_i && mb.ack && !to_now));
            checkOutput("instr_err", 32'(ib.err), 32'(g_i && (mb.err || to_now)));
            checkOutput("data_ack", 32'(db.ack), 32'(g_d && mb.ack && !to_now));
            checkOutput("data_err", 32'(db.err), 32'(g_d && (mb.err || to_now)));
        end
    end

    // Drive one cycle of inputs just after the clock edge, return at mid-cycle.
    task automatic applyStimulus(input bit rn, input bit ic, input bit is, input bit dc, input bit ds,
                                 input bit ack, input bit err, input logic [31:0] iadr, input logic [31:0] dadr);
        @(posedge clk);
        #1;
        cyc_no++;
        rst_n    = rn;
        ib.cyc   = ic;   ib.stb = is;  ib.we = 1'b0; ib.sel = 4'hF;
        ib.adr   = iadr; ib.dat_w = iadr ^ 32'hA5A5_0000;
        db.cyc   = dc;   db.stb = ds;  db.we = 1'b1; db.sel = 4'h3;
        db.adr   = dadr; db.dat_w = dadr ^ 32'h5A5A_0000;
        mb.ack   = ack;  mb.err = err;
        mb.dat_r = 32'hD000_0000 | 32'(cyc_no);
        @(negedge clk);
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        ib.cyc = 0; ib.stb = 0; ib.we = 0; ib.sel = 0; ib.adr = 0; ib.dat_w = 0;
        db.cyc = 0; db.stb = 0; db.we = 0; db.sel = 0; db.adr = 0; db.dat_w = 0;
        mb.ack = 0; mb.err = 0; mb.dat_r = 0;

        // Single instruction fetch
        doReset();
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 32'h100, 32'h0);
        checkOutput("s1_owner_c0", 32'(owner), 32'h0);
        checkOutput("s1_cyc_c0", 32'(mb.cyc), 32'h0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 32'h100, 32'h0);
        checkOutput("s1_owner_c1", 32'(owner), 32'h1);
        checkOutput("s1_adr_c1", mb.adr, 32'h100);
        applyStimulus(1, 1, 1, 0, 0, 1, 0, 32'h100, 32'h0);
        checkOutput("s1_iack_c2", 32'(ib.ack), 32'h1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h100, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h100, 32'h0);
        checkOutput("s1_owner_c4", 32'(owner), 32'h0);

        // Contention and round-robin
        doReset();
        applyStimulus(1, 1, 1, 1, 1, 0, 0, 32'h104, 32'h200);
        applyStimulus(1, 1, 1, 1, 1, 0, 0, 32'h104, 32'h200);
        checkOutput("s2_owner_data_first", 32'(owner), 32'h2);
        checkOutput("s2_adr_data", mb.adr, 32'h200);
        applyStimulus(1, 1, 1, 1, 1, 1, 0, 32'h104, 32'h200);
        checkOutput("s2_dack", 32'(db.ack), 32'h1);
        checkOutput("s2_iack_blocked", 32'(ib.ack), 32'h0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 32'h104, 32'h200);
        applyStimulus(1, 1, 1, 1, 1, 0, 0, 32'h104, 32'h204);
        checkOutput("s2_owner_idle", 32'(owner), 32'h0);
        applyStimulus(1, 1, 1, 1, 1, 0, 0, 32'h104, 32'h204);
        checkOutput("s2_owner_instr_tie", 32'(owner), 32'h1);
        applyStimulus(1, 1, 1, 1, 1, 1, 0, 32'h104, 32'h204);
        applyStimulus(1, 0, 0, 1, 1, 0, 0, 32'h104, 32'h204);
        applyStimulus(1, 1, 1, 1, 1, 0, 0, 32'h108, 32'h204);
        applyStimulus(1, 1, 1, 1, 1, 0, 0, 32'h108, 32'h204);
        checkOutput("s2_owner_data_tie", 32'(owner), 32'h2);
        applyStimulus(1, 1, 1, 1, 1, 1, 0, 32'h108, 32'h204);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

        // Multi-beat data burst with a strobe gap
        doReset();
        applyStimulus(1, 1, 1, 1, 1, 0, 0, 32'h110, 32'h300);
        applyStimulus(1, 1, 1, 1, 1, 1, 0, 32'h110, 32'h300);
        checkOutput("s3_owner_b1", 32'(owner), 32'h2);
        applyStimulus(1, 1, 1, 1, 0, 0, 0, 32'h110, 32'h304);
        checkOutput("s3_stb_gap", 32'(mb.stb), 32'h0);
        checkOutput("s3_cyc_gap", 32'(mb.cyc), 32'h1);
        applyStimulus(1, 1, 1, 1, 1, 1, 0, 32'h110, 32'h304);
        checkOutput("s3_adr_b2", mb.adr, 32'h304);
        applyStimulus(1, 1, 1, 1, 1, 1, 0, 32'h110, 32'h308);
        checkOutput("s3_iack_b3", 32'(ib.ack), 32'h0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 32'h110, 32'h308);
        checkOutput("s3_owner_end", 32'(owner), 32'h2);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 32'h110, 32'h308);
        applyStimulus(1, 1, 1, 0, 0, 1, 0, 32'h110, 32'h308);
        checkOutput("s3_owner_instr", 32'(owner), 32'h1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

        // Timeout: memory never answers the data port
        doReset();
        applyStimulus(1, 1, 1, 1, 1, 0, 0, 32'h120, 32'h400);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 1, 1, 1, 0, 0, 32'h120, 32'h400);
            checkOutput("s4_no_err_yet", 32'(db.err), 32'h0);
        end
        applyStimulus(1, 1, 1, 1, 1, 0, 0, 32'h120, 32'h400);
        checkOutput("s4_derr", 32'(db.err), 32'h1);
        checkOutput("s4_stb_held", 32'(mb.stb), 32'h0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 32'h120, 32'h400);
        checkOutput("s4_owner_idle", 32'(owner), 32'h0);
        applyStimulus(1, 1, 1, 0, 0, 1, 0, 32'h120, 32'h400);
        checkOutput("s4_owner_instr", 32'(owner), 32'h1);
        checkOutput("s4_iack", 32'(ib.ack), 32'h1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

        // Dropping stb pauses the wait count
        doReset();
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 32'h130, 32'h0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 32'h130, 32'h0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h130, 32'h0);
        end
        checkOutput("s5_no_err_idle_stb", 32'(ib.err), 32'h0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 32'h130, 32'h0);
        applyStimulus(1, 1, 1, 0, 0, 1, 0, 32'h130, 32'h0);
        checkOutput("s5_iack", 32'(ib.ack), 32'h1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

        // Reset in the middle of a data wait
        doReset();
        applyStimulus(1, 0, 0, 1, 1, 0, 0, 32'h0, 32'h500);
        applyStimulus(1, 0, 0, 1, 1, 0, 0, 32'h0, 32'h500);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 32'h0, 32'h500);
        checkOutput("s6_owner_before_rst", 32'(owner), 32'h2);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h500);
        checkOutput("s6_cyc_after_rst", 32'(mb.cyc), 32'h0);
        checkOutput("s6_dack_dropped", 32'(db.ack), 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
        checkOutput("s6_iack_dropped", 32'(ib.ack), 32'h0);

        // Stray ack in IDLE, then an error response
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
        checkOutput("s7_stray_iack", 32'(ib.ack), 32'h0);
        checkOutput("s7_stray_dack", 32'(db.ack), 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        checkOutput("s7_owner_idle", 32'(owner), 32'h0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 32'h140, 32'h0);
        applyStimulus(1, 1, 1, 0, 0, 0, 1, 32'h140, 32'h0);
        checkOutput("s7_ierr", 32'(ib.err), 32'h1);
        checkOutput("s7_derr", 32'(db.err), 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
